tx_sequencer: RTL and testbench

TX_SEQUENCER -- requirements
Module: tx_sequencer

---
 rtl/tx_sequencer.sv | 147 ++++++++++++++
 tb/tb_tx_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/tx_sequencer.sv
// Link transmit sequencer: OFF -> TRAIN (COM burst) -> ACTIVE payload, with periodic
// SKP ordered sets inserted only when TX_SEQ_SKP_INSERT_EN is defined.
module tx_sequencer #(
  parameter int TRAIN_LEN    = 16,
  parameter int SKP_INTERVAL = 64
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       tx_en,
  input  logic [7:0] data_in,
  input  logic       data_k,
  input  logic       data_valid,
  output logic       data_ready,
  output logic [7:0] out_8b,
  output logic       K,
  output logic       ENB,
  output logic       link_up
);

  localparam int TW = (TRAIN_LEN > 1) ? $clog2(TRAIN_LEN) : 1;
  localparam logic [TW-1:0] TRAIN_LAST = TW'(TRAIN_LEN - 1);
  localparam logic [7:0] COM  = 8'hBC;
  localparam logic [7:0] IDLE = 8'h00;

`ifdef TX_SEQ_SKP_INSERT_EN
  typedef enum logic [1:0] {OFF, TRAIN, ACTIVE, SKP} state_t;
  localparam int SW = $clog2(SKP_INTERVAL);
  localparam logic [SW-1:0] SKP_LAST = SW'(SKP_INTERVAL - 1);
  localparam logic [7:0] SKP_SYM = 8'h1C;
  logic [SW-1:0] skp_cnt, skp_cnt_n;
  logic [1:0]    sym_cnt, sym_cnt_n;
`else
  typedef enum logic [1:0] {OFF, TRAIN, ACTIVE} state_t;
`endif

  state_t        state, state_n;
  logic [TW-1:0] train_cnt, train_cnt_n;
  logic [7:0]    out_n;
  logic          k_n, enb_n, link_n;
  logic          xfer;

  // Ready is gated by tx_en so a byte is never accepted on the edge that shuts the link down.
  always_comb begin
    data_ready = 1'b0;
    if (state == ACTIVE && tx_en) data_ready = 1'b1;
`ifdef TX_SEQ_SKP_INSERT_EN
    if (skp_cnt == SKP_LAST) data_ready = 1'b0;
`endif
  end

  assign xfer = data_valid & data_ready;

  // Registered outputs always describe the state being entered at the same edge.
  always_comb begin
    state_n     = state;
    train_cnt_n = '0;
    out_n       = IDLE;
    k_n         = 1'b0;
    enb_n       = 1'b0;
    link_n      = 1'b0;
`ifdef TX_SEQ_SKP_INSERT_EN
    skp_cnt_n   = '0;
    sym_cnt_n   = '0;
`endif
    if (!tx_en) begin
      state_n = OFF;
    end else begin
      case (state)
        OFF: begin
          state_n = TRAIN;
          out_n   = COM;
          k_n     = 1'b1;
          enb_n   = 1'b1;
        end
        TRAIN: begin
          enb_n = 1'b1;
          if (train_cnt == TRAIN_LAST) begin
            state_n = ACTIVE;
            link_n  = 1'b1;
          end else begin
            train_cnt_n = train_cnt + 1'b1;
            out_n       = COM;
            k_n         = 1'b1;
          end
        end
        ACTIVE: begin
          enb_n  = 1'b1;
          link_n = 1'b1;
          if (xfer) begin
            out_n = data_in;
            k_n   = data_k;
          end
`ifdef TX_SEQ_SKP_INSERT_EN
          if (skp_cnt == SKP_LAST) begin
            state_n = SKP;
            out_n   = COM;
            k_n     = 1'b1;
          end else begin
            skp_cnt_n = skp_cnt + 1'b1;
          end
`endif
        end
`ifdef TX_SEQ_SKP_INSERT_EN
        SKP: begin
          enb_n  = 1'b1;
          link_n = 1'b1;
          if (sym_cnt == 2'd3) begin
            state_n = ACTIVE;
          end else begin
            sym_cnt_n = sym_cnt + 1'b1;
            out_n     = SKP_SYM;
            k_n       = 1'b1;
          end
        end
`endif
        default: state_n = OFF;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state     <= OFF;
      train_cnt <= '0;
      out_8b    <= IDLE;
      K         <= 1'b0;
      ENB       <= 1'b0;
      link_up   <= 1'b0;
`ifdef TX_SEQ_SKP_INSERT_EN
      skp_cnt   <= '0;
      sym_cnt   <= '0;
`endif
    end else begin
      state     <= state_n;
      train_cnt <= train_cnt_n;
      out_8b    <= out_n;
      K         <= k_n;
      ENB       <= enb_n;
      link_up   <= link_n;
`ifdef TX_SEQ_SKP_INSERT_EN
      skp_cnt   <= skp_cnt_n;
      sym_cnt   <= sym_cnt_n;
`endif
    end
  end

endmodule

// File: tb/tb_tx_sequencer.sv
// Testbench for tx_sequencer: randomized payload checked against a cycle-position model
// of the transmit stream; adapts to TX_SEQ_SKP_INSERT_EN being defined or not.
module tb_tx_sequencer;

  localparam int TRAIN_LEN    = 16;
  localparam int SKP_INTERVAL = 64;
`ifdef TX_SEQ_SKP_INSERT_EN
  localparam bit SKP_ON = 1'b1;
`else
  localparam bit SKP_ON = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       reset, tx_en, data_k, data_valid;
  logic [7:0] data_in;
  logic       data_ready, K, ENB, link_up;
  logic [7:0] out_8b;

  int checks = 0;
  int failures = 0;

  // Model: pos = cycles since TRAIN was entered (-1 when off), plus the byte accepted last edge.
  int         pos = -1;
  bit         have_prev = 1'b0;
  logic [7:0] prev_byte = 8'h00;
  logic       prev_k = 1'b0;
  logic [7:0] next_byte = 8'h01;

  tx_sequencer #(.TRAIN_LEN(TRAIN_LEN), .SKP_INTERVAL(SKP_INTERVAL)) dut (
    .CLK(CLK), .reset(reset), .tx_en(tx_en), .data_in(data_in), .data_k(data_k),
    .data_valid(data_valid), .data_ready(data_ready), .out_8b(out_8b), .K(K),
    .ENB(ENB), .link_up(link_up)
  );

  always #5 CLK = ~CLK;

  task automatic modelExpect(output logic [7:0] e_out, output logic e_k, output logic e_enb,
                             output logic e_link, output logic e_ready);
    int p;
    e_out = 8'h00; e_k = 1'b0; e_enb = 1'b0; e_link = 1'b0; e_ready = 1'b0;
    if (pos < 0) return;
    e_enb = 1'b1;
    if (pos < TRAIN_LEN) begin
      e_out = 8'hBC; e_k = 1'b1;
      return;
    end
    e_link = 1'b1;
    p = SKP_ON ? (pos - TRAIN_LEN) % (SKP_INTERVAL + 4) : 0;
    if (SKP_ON && p >= SKP_INTERVAL) begin
      e_out = (p == SKP_INTERVAL) ? 8'hBC : 8'h1C;
      e_k   = 1'b1;
    end else begin
      e_ready = !(SKP_ON && p == SKP_INTERVAL - 1);
      if (have_prev) begin
        e_out = prev_byte; e_k = prev_k;
      end
    end
  endtask

`ifdef TX_SEQ_SKP_INSERT_EN
  function automatic int curSkpIdx();
    int p;
    if (pos < TRAIN_LEN) return -1;
    p = (pos - TRAIN_LEN) % (SKP_INTERVAL + 4);
    return (p >= SKP_INTERVAL) ? p - SKP_INTERVAL : -1;
  endfunction
`endif

  task automatic checkOutput();
    logic [7:0] eo;
    logic ek, ee, el, er;
    modelExpect(eo, ek, ee, el, er);
    checks++;
    assert (out_8b === eo) else begin
      failures++; $error("[TB] FAIL out_8b pos=%0d observed=%02h expected=%02h", pos, out_8b, eo);
    end
    checks++;
    assert (K === ek) else begin
      failures++; $error("[TB] FAIL K pos=%0d observed=%0b expected=%0b", pos, K, ek);
    end
    checks++;
    assert (ENB === ee) else begin
      failures++; $error("[TB] FAIL ENB pos=%0d observed=%0b expected=%0b", pos, ENB, ee);
    end
    checks++;
    assert (link_up === el) else begin
      failures++; $error("[TB] FAIL link_up pos=%0d observed=%0b expected=%0b", pos, link_up, el);
    end
  endtask

  // One cycle: drive at the falling edge, check ready, advance the model at the rising edge.
  task automatic applyStimulus(input logic en, input logic rst, input logic valid,
                               input logic [7:0] d, input logic kk);
    logic [7:0] eo;
    logic ek, ee, el, er;
    reset = rst; tx_en = en; data_valid = valid; data_in = d; data_k = kk;
    #1;
    modelExpect(eo, ek, ee, el, er);
    checks++;
    assert (data_ready === (er & en)) else begin
      failures++; $error("[TB] FAIL data_ready pos=%0d observed=%0b expected=%0b", pos, data_ready, er & en);
    end
    @(posedge CLK);
    if (rst || !en) begin
      pos = -1; have_prev = 1'b0;
    end else begin
      have_prev = valid && er;
      if (have_prev) begin
        prev_byte = d; prev_k = kk;
      end
      pos = (pos < 0) ? 0 : pos + 1;
    end
    @(negedge CLK);
    checkOutput();
  endtask

  initial begin
    int waited;
    reset = 1'b1; tx_en = 1'b0; data_valid = 1'b0; data_in = 8'h00; data_k = 1'b0;
    @(negedge CLK);
    checkOutput();
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

    $display("[TB] training then streaming with valid held");
    for (int i = 0; i < 220; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, next_byte, 1'b0);
      if (have_prev) next_byte++;
    end

    $display("[TB] idle stream");
    repeat (140) applyStimulus(1'b1, 1'b0, 1'b0, 8'h55, 1'b0);

    $display("[TB] random payload");
    for (int i = 0; i < 300; i++)
      applyStimulus(1'b1, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) == 0));

`ifdef TX_SEQ_SKP_INSERT_EN
    $display("[TB] drop tx_en on second SKP ordered-set symbol");
    waited = 0;
    while (curSkpIdx() != 1 && waited < 200) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 8'($urandom), 1'b0);
      waited++;
    end
    checks++;
    assert (waited < 200) else begin
      failures++; $error("[TB] FAIL skp_wait observed=%0d expected=<200", waited);
    end
`else
    waited = 0;
`endif
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b1, 8'hA5, 1'b0);

    $display("[TB] full retrain");
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, next_byte, 1'b0);
      if (have_prev) next_byte++;
    end

    $display("[TB] reset mid-train");
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    repeat (6) applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h33, 1'b0);
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, next_byte, 1'b0);
      if (have_prev) next_byte++;
    end

    $display("[TB] random enable toggling");
    for (int i = 0; i < 400; i++)
      applyStimulus(1'($urandom_range(0, 39) != 0), 1'($urandom_range(0, 99) == 0),
                    1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) == 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
